// File: rtl/mfp_reset_pkg.sv
// Shared definitions for the board reset sequencer:
// FSM state encoding, reset_cause bit positions and sizing helper.
package mfp_reset_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_STAGGER = 2'd1,
        ST_RUN     = 2'd2,
        ST_WARM    = 2'd3
    } state_t;

    localparam int CAUSE_KEY   = 0;
    localparam int CAUSE_EJTAG = 1;
    localparam int CAUSE_PLL   = 2;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mfp_reset_sync_debounce.sv
// Two-flop synchroniser followed by a stable-count filter.
// Unfiltered edges pass straight through to filt_o in the same cycle.
module mfp_reset_sync_debounce #(
    parameter int   CYCLES    = 4,
    parameter logic RST_VAL   = 1'b1,
    parameter bit   FILT_RISE = 1'b1,
    parameter bit   FILT_FALL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic filt_o
);

    localparam int CW = $clog2(CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          meta_q;
    logic          sync_q;
    logic          acc_q;
    logic          acc_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          differ;
    logic          filtered;

    assign differ   = sync_q != acc_q;
    assign filtered = sync_q ? FILT_RISE : FILT_FALL;

    always_comb begin
        acc_d = acc_q;
        cnt_d = '0;
        if (differ) begin
            if (!filtered || cnt_q >= CNT_LAST) begin
                acc_d = sync_q;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            acc_q  <= RST_VAL;
            cnt_q  <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
        end
    end

    // A falling edge that is not filtered must drop the output immediately.
    assign filt_o = (acc_q | (~FILT_RISE & sync_q)) & (sync_q | FILT_FALL);

endmodule

// File: rtl/mfp_reset_sequencer.sv
// Board reset controller: merges key, probe and PLL-lock sources into
// ordered cold and system resets with minimum hold and release stagger.
module mfp_reset_sequencer
    import mfp_reset_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LOCK_CYCLES     = 1024,
    parameter int HOLD_CYCLES     = 64,
    parameter int STAGGER_CYCLES  = 16
) (
    input  logic       SI_ClkIn,
    input  logic       SI_Reset,
    input  logic       key_rst_n,
    input  logic       ej_rst_n,
    input  logic       pll_locked,
    input  logic       cause_clr,
    output logic       cold_reset,
    output logic       sys_reset,
    output logic       reset_done,
    output logic [2:0] reset_cause
);

    localparam int CW = $clog2(max2(HOLD_CYCLES, STAGGER_CYCLES)) + 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic          key_acc;
    logic          lock_ok;
    logic          ej_meta_q;
    logic          ej_sync_q;
    logic          cold_src;
    logic          warm_src;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_inc;
    logic [2:0]    cause_q;
    logic [2:0]    cause_d;
    logic [2:0]    cause_set;
    logic [2:0]    cold_bits;
    logic          cold_q;
    logic          sys_q;
    logic          done_q;

    mfp_reset_sync_debounce #(
        .CYCLES    (DEBOUNCE_CYCLES),
        .RST_VAL   (1'b1),
        .FILT_RISE (1'b1),
        .FILT_FALL (1'b1)
    ) u_key (
        .clk_i  (SI_ClkIn),
        .rst_i  (SI_Reset),
        .d_i    (key_rst_n),
        .filt_o (key_acc)
    );

    mfp_reset_sync_debounce #(
        .CYCLES    (LOCK_CYCLES),
        .RST_VAL   (1'b0),
        .FILT_RISE (1'b1),
        .FILT_FALL (1'b0)
    ) u_lock (
        .clk_i  (SI_ClkIn),
        .rst_i  (SI_Reset),
        .d_i    (pll_locked),
        .filt_o (lock_ok)
    );

    assign cold_src = ~lock_ok | ~ej_sync_q;
    assign warm_src = ~key_acc;
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;

    always_comb begin
        cold_bits              = '0;
        cold_bits[CAUSE_PLL]   = ~lock_ok;
        cold_bits[CAUSE_EJTAG] = ~ej_sync_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cause_set = '0;
        unique case (state_q)
            ST_HOLD: begin
                if (cold_src || warm_src) begin
                    cnt_d = '0;
                end else if (cnt_q >= HOLD_LAST) begin
                    state_d = ST_STAGGER;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_STAGGER: begin
                if (cold_src) begin
                    state_d   = ST_HOLD;
                    cnt_d     = '0;
                    cause_set = cold_bits;
                end else if (warm_src) begin
                    cnt_d = '0;
                end else if (cnt_q >= STAG_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (cold_src) begin
                    state_d   = ST_HOLD;
                    cause_set = cold_bits;
                end else if (warm_src) begin
                    state_d              = ST_WARM;
                    cause_set[CAUSE_KEY] = 1'b1;
                end
            end
            ST_WARM: begin
                if (cold_src) begin
                    state_d   = ST_HOLD;
                    cnt_d     = '0;
                    cause_set = cold_bits;
                end else if (warm_src) begin
                    cnt_d = '0;
                end else if (cnt_q >= HOLD_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
        endcase
        // A set in the same cycle as a clear must survive.
        cause_d = (cause_clr ? 3'b000 : cause_q) | cause_set;
    end

    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            ej_meta_q <= 1'b1;
            ej_sync_q <= 1'b1;
            state_q   <= ST_HOLD;
            cnt_q     <= '0;
            cause_q   <= '0;
            cold_q    <= 1'b1;
            sys_q     <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            ej_meta_q <= ej_rst_n;
            ej_sync_q <= ej_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cause_q   <= cause_d;
            cold_q    <= state_d == ST_HOLD;
            sys_q     <= state_d != ST_RUN;
            done_q    <= state_d == ST_RUN;
        end
    end

    assign cold_reset  = cold_q;
    assign sys_reset   = sys_q;
    assign reset_done  = done_q;
    assign reset_cause = cause_q;

endmodule

// File: tb/tb_mfp_reset_sequencer.sv
// Self-checking bench for mfp_reset_sequencer: directed scenarios plus
// randomised source activity against a behavioural reference model.
module tb_mfp_reset_sequencer;

    localparam int DEB = 4;
    localparam int LCK = 4;
    localparam int HLD = 8;
    localparam int STG = 4;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       key_n = 1'b1;
    logic       ej_n  = 1'b1;
    logic       pll   = 1'b1;
    logic       clr   = 1'b0;
    logic       cold;
    logic       sys;
    logic       done;
    logic [2:0] cause;

    int vec  = 0;
    int miss = 0;

    always #5 clk = ~clk;

    mfp_reset_sequencer #(
        .DEBOUNCE_CYCLES (DEB),
        .LOCK_CYCLES     (LCK),
        .HOLD_CYCLES     (HLD),
        .STAGGER_CYCLES  (STG)
    ) dut (
        .SI_ClkIn    (clk),
        .SI_Reset    (rst),
        .key_rst_n   (key_n),
        .ej_rst_n    (ej_n),
        .pll_locked  (pll),
        .cause_clr   (clr),
        .cold_reset  (cold),
        .sys_reset   (sys),
        .reset_done  (done),
        .reset_cause (cause)
    );

    // Reference model: sources are described by run lengths of synced
    // samples; each mode ends once enough quiet cycles have accumulated.
    typedef enum {M_HOLD, M_STAG, M_RUN, M_WARM} mmode_t;
    mmode_t     mode;
    logic [1:0] k_pipe, e_pipe, p_pipe;
    logic       k_acc;
    int         k_diff, p_run, quiet;
    logic [2:0] m_cause;
    logic       m_cold, m_sys, m_done;

    always @(posedge clk) begin : model
        logic lk, csrc, wsrc;
        logic [2:0] add;
        if (rst) begin
            mode = M_HOLD; quiet = 0;
            k_pipe = 2'b11; e_pipe = 2'b11; p_pipe = 2'b00;
            k_acc = 1'b1; k_diff = 0; p_run = 0; m_cause = 3'b000;
        end else begin
            lk   = p_pipe[1] && (p_run >= LCK);
            csrc = !lk || !e_pipe[1];
            wsrc = !k_acc;
            add  = 3'b000;
            case (mode)
                M_HOLD: begin
                    quiet = (csrc || wsrc) ? 0 : quiet + 1;
                    if (quiet >= HLD) begin mode = M_STAG; quiet = 0; end
                end
                M_STAG: begin
                    if (csrc) begin
                        mode = M_HOLD; quiet = 0; add = {!lk, !e_pipe[1], 1'b0};
                    end else begin
                        quiet = wsrc ? 0 : quiet + 1;
                        if (quiet >= STG) begin mode = M_RUN; quiet = 0; end
                    end
                end
                M_RUN: begin
                    if (csrc) begin
                        mode = M_HOLD; quiet = 0; add = {!lk, !e_pipe[1], 1'b0};
                    end else if (wsrc) begin
                        mode = M_WARM; quiet = 0; add = 3'b001;
                    end
                end
                M_WARM: begin
                    if (csrc) begin
                        mode = M_HOLD; quiet = 0; add = {!lk, !e_pipe[1], 1'b0};
                    end else begin
                        quiet = wsrc ? 0 : quiet + 1;
                        if (quiet >= HLD) begin mode = M_RUN; quiet = 0; end
                    end
                end
            endcase
            m_cause = (clr ? 3'b000 : m_cause) | add;
            if (k_pipe[1] != k_acc) begin
                k_diff++;
                if (k_diff >= DEB) begin k_acc = k_pipe[1]; k_diff = 0; end
            end else begin
                k_diff = 0;
            end
            p_run  = p_pipe[1] ? p_run + 1 : 0;
            k_pipe = {k_pipe[0], key_n};
            e_pipe = {e_pipe[0], ej_n};
            p_pipe = {p_pipe[0], pll};
        end
        m_cold = mode == M_HOLD;
        m_sys  = mode != M_RUN;
        m_done = mode == M_RUN;
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) tick();
        vec++;
        if ({cold, sys, done, cause} !== 6'b110000) begin
            miss++;
            $display("FAIL reset_state got %b want 110000", {cold, sys, done, cause});
        end
    endtask

    task automatic test_powerup;
        int fc, fs;
        fc = -1; fs = -1;
        rst = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            vec++;
            if ({cold, sys, done, cause} !== {m_cold, m_sys, m_done, m_cause}) begin
                miss++;
                $display("FAIL powerup_c%0d got %b want %b", i,
                         {cold, sys, done, cause}, {m_cold, m_sys, m_done, m_cause});
            end
            if (fc < 0 && !cold) fc = i;
            if (fs < 0 && !sys) fs = i;
        end
        vec++;
        if (fc != 2 + LCK + HLD) begin
            miss++; $display("FAIL powerup_cold_fall got %0d want %0d", fc, 2 + LCK + HLD);
        end
        vec++;
        if (fs != 2 + LCK + HLD + STG) begin
            miss++; $display("FAIL powerup_sys_fall got %0d want %0d", fs, 2 + LCK + HLD + STG);
        end
        vec++;
        if ({done, cause} !== 4'b1000) begin
            miss++; $display("FAIL powerup_done_cause got %b want 1000", {done, cause});
        end
    endtask

    task automatic test_key_glitch;
        key_n = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (i == 3) key_n = 1'b1;
            vec++;
            if ({cold, sys, done} !== 3'b001 || {cold, sys, done} !== {m_cold, m_sys, m_done}) begin
                miss++;
                $display("FAIL key_glitch_c%0d got %b want 001", i, {cold, sys, done});
            end
        end
    endtask

    task automatic test_key_press;
        int fr, rl;
        bit cold_seen;
        fr = -1; rl = -1; cold_seen = 0;
        key_n = 1'b0;
        for (int i = 1; i <= 45; i++) begin
            tick();
            if (i == 20) key_n = 1'b1;
            vec++;
            if ({cold, sys, done, cause} !== {m_cold, m_sys, m_done, m_cause}) begin
                miss++;
                $display("FAIL key_press_c%0d got %b want %b", i,
                         {cold, sys, done, cause}, {m_cold, m_sys, m_done, m_cause});
            end
            if (cold) cold_seen = 1;
            if (fr < 0 && sys) fr = i;
            if (fr > 0 && rl < 0 && !sys) rl = i;
        end
        vec++;
        if (fr != 2 + DEB + 1) begin
            miss++; $display("FAIL key_assert got %0d want %0d", fr, 2 + DEB + 1);
        end
        vec++;
        if (rl != 20 + 2 + DEB + HLD) begin
            miss++; $display("FAIL key_release got %0d want %0d", rl, 20 + 2 + DEB + HLD);
        end
        vec++;
        if (cold_seen || cause !== 3'b001) begin
            miss++; $display("FAIL key_cause got cold=%0d cause=%b want cold=0 cause=001",
                             cold_seen, cause);
        end
    endtask

    task automatic test_pll_loss;
        int fc, dn;
        fc = -1; dn = -1;
        clr = 1'b1; tick(); clr = 1'b0;
        pll = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 1) pll = 1'b1;
            vec++;
            if ({cold, sys, done, cause} !== {m_cold, m_sys, m_done, m_cause}) begin
                miss++;
                $display("FAIL pll_loss_c%0d got %b want %b", i,
                         {cold, sys, done, cause}, {m_cold, m_sys, m_done, m_cause});
            end
            if (fc < 0 && cold && sys) fc = i;
            if (fc > 0 && dn < 0 && done) dn = i;
        end
        vec++;
        if (fc != 3) begin
            miss++; $display("FAIL pll_loss_assert got %0d want 3", fc);
        end
        vec++;
        if (dn != 3 + LCK + HLD + STG) begin
            miss++; $display("FAIL pll_relock_done got %0d want %0d", dn, 3 + LCK + HLD + STG);
        end
        vec++;
        if (cause !== 3'b100) begin
            miss++; $display("FAIL pll_cause got %b want 100", cause);
        end
    endtask

    task automatic test_ejtag_stagger;
        int n, fc, fl;
        n = 0; fc = -1; fl = -1;
        rst = 1'b1; tick(); rst = 1'b0;
        while (cold && n < 40) begin tick(); n++; end
        vec++;
        if (cold) begin
            miss++; $display("FAIL ej_reach_stagger got cold=1 want 0 after %0d", n);
        end
        ej_n = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 5) ej_n = 1'b1;
            vec++;
            if ({cold, sys, done, cause} !== {m_cold, m_sys, m_done, m_cause}) begin
                miss++;
                $display("FAIL ej_stagger_c%0d got %b want %b", i,
                         {cold, sys, done, cause}, {m_cold, m_sys, m_done, m_cause});
            end
            if (fc < 0 && cold) fc = i;
            if (fc > 0 && fl < 0 && !cold) fl = i;
        end
        vec++;
        if (fc != 3) begin
            miss++; $display("FAIL ej_reassert got %0d want 3", fc);
        end
        vec++;
        if (fl != 5 + 2 + HLD) begin
            miss++; $display("FAIL ej_hold_restart got %0d want %0d", fl, 5 + 2 + HLD);
        end
        vec++;
        if ({done, cause} !== 4'b1010) begin
            miss++; $display("FAIL ej_cause got %b want 1010", {done, cause});
        end
    endtask

    task automatic test_simultaneous;
        int fc;
        bit hold_ok;
        fc = -1; hold_ok = 0;
        clr = 1'b1; tick(); clr = 1'b0;
        key_n = 1'b0; pll = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 10) begin key_n = 1'b1; pll = 1'b1; end
            vec++;
            if ({cold, sys, done, cause} !== {m_cold, m_sys, m_done, m_cause}) begin
                miss++;
                $display("FAIL simul_c%0d got %b want %b", i,
                         {cold, sys, done, cause}, {m_cold, m_sys, m_done, m_cause});
            end
            if (fc < 0 && sys) begin fc = i; hold_ok = cold; end
        end
        vec++;
        if (fc != 3 || !hold_ok) begin
            miss++; $display("FAIL simul_hold got cyc=%0d cold=%0d want cyc=3 cold=1", fc, hold_ok);
        end
        vec++;
        if ({done, cause} !== 4'b1100) begin
            miss++; $display("FAIL simul_cause got %b want 1100", {done, cause});
        end
        clr = 1'b1; tick(); clr = 1'b0;
        vec++;
        if (cause !== 3'b000) begin
            miss++; $display("FAIL cause_clr got %b want 000", cause);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) key_n = ~key_n;
            if (pll) pll = ($urandom_range(0, 199) != 0);
            else     pll = ($urandom_range(0, 2) == 0);
            if (ej_n) ej_n = ($urandom_range(0, 299) != 0);
            else      ej_n = ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 49) == 0);
            rst = ($urandom_range(0, 999) == 0);
            tick();
            vec++;
            if ({cold, sys, done, cause} !== {m_cold, m_sys, m_done, m_cause}) begin
                miss++;
                $display("FAIL random_c%0d got %b want %b", i,
                         {cold, sys, done, cause}, {m_cold, m_sys, m_done, m_cause});
            end
            vec++;
            if (cold && !sys) begin
                miss++; $display("FAIL random_order_c%0d got cold=1 sys=0 want sys=1", i);
            end
        end
        rst = 1'b0; clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_key_glitch();
        test_key_press();
        test_pll_loss();
        test_ejtag_stagger();
        test_simultaneous();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
